loop_arbiter: RTL and testbench
===============================

Name: loop_arbiter

Overview:
- Registered round-robin ("loop") arbiter for N requesters, one-hot grant.
- Sits in front of a shared resource (bus/port); each cycle picks the next active requester after the last granted one, wrapping from N-1 to 0.
- `arb_en` freezes the current grant for multi-cycle ownership.

Parameters:
- N, default 7: number of requesters; legal range 2..32; sets the width of `req` and `grant`.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `arb_en`, input, 1: grant hold. 1 = freeze current grant and pointer; 0 = arbitrate every cycle.
- `req`, input, N: request vector; bit i = requester i wants access.
- `grant`, output, N: registered grant, one-hot or all-zero.

Behaviour:
- State:
  - `grant` register, N bits.
  - Last-winner pointer `last`, ceil(log2 N) bits.
- Reset (`rst`=1 at posedge): `grant` <= 0; `last` <= N-1, so requester 0 has top priority first. Reset overrides everything and applies mid-operation too, dropping any held grant.
- Arbitration (`arb_en`=0), each posedge:
  - Search `req` starting at index (`last`+1) mod N, ascending with wrap; the first set bit k wins.
  - `grant` <= one-hot(k); `last` <= k.
  - Latency: 1 cycle from `req` sampled to `grant` visible. No combinational path from `req` to `grant`.
- No request (`req`==0, `arb_en`=0): `grant` <= 0; `last` unchanged.
- Single request: granted whenever `arb_en`=0, including back-to-back repeats of the same index.
- Fairness: with all N bits held high, grants rotate 0,1,...,N-1,0,...; each requester waits at most N-1 grants.
- Hold (`arb_en`=1), each posedge:
  - `grant` and `last` keep their values regardless of `req`, including when the held requester drops `req`.
  - If `grant` was 0, it stays 0.
- Release: when `arb_en` returns to 0, arbitration resumes from the stored `last`.
- Invariant: `grant` has at most one bit set; a set bit i implies `req`[i] was 1 at the posedge that loaded it (or at the posedge before the hold began).

Optional Feature:
- Macro LOOP_ARB_CHECK_EN.
- Defined: synthesis-off concurrent assertions are compiled in:
  - `grant` is one-hot or zero every cycle.
  - When `arb_en`=0 in the previous cycle, each `grant` bit is a subset of that cycle's `req`.
  - `grant` is stable across cycles where `arb_en` was 1.
  - `grant`==0 in the cycle after `rst`.
  - A violation reports via `$error`.
- Undefined: no checker logic; RTL function identical.

Decomposition:
- Package `loop_arbiter_pkg`:
  - localparam default N (7).
  - function `clog2`-based pointer width.
  - function `onehot(idx)`.
- One sub-module, `loop_arbiter_pick`: purely combinational rotating-priority picker. Inputs: `req`[N], `last` pointer. Outputs: winner index, valid. Implement as double-width masked priority encode.
- Top module holds the two registers, hold mux and reset.

Test Plan:
- Reset then first pick: `rst`=1 for 2 cycles; `grant`==0; then `req`=7'b1001010, `arb_en`=0 -> next cycle `grant`=7'b0000010.
- Rotation past last winner: after previous, `req`=7'b1001001 -> `grant`=7'b0001000; then `req`=7'b1001101 -> `grant`=7'b1000000 (skips bits 4,5).
- Wrap and full rotation: `req`=7'b1001101 held from `last`=6 -> grants 0000001, 0000100, 0001000, 1000000, 0000001.
- All requesting: `req`=7'h7F for 8 cycles after reset -> grants bit0..bit6, then bit0.
- Idle and hold:
  - `req`=0 -> `grant`=0 and pointer kept; next `req`=7'b0010001 after `last`=3 -> bit4.
  - `arb_en`=1 while `grant`=bit4 with `req` changed to 7'b0000001 -> `grant` stays bit4.
  - `arb_en`=0 -> bit0.
- Reset mid-hold: `arb_en`=1, `grant`=bit2, assert `rst` one cycle -> `grant`=0; release with `req`=7'h7F, `arb_en`=0 -> bit0.

Source files
------------

// File: rtl/loop_arbiter_pkg.sv
// Shared types and helpers for the round-robin loop arbiter: default size,
// pointer width and one-hot encoding.
package loop_arbiter_pkg;

  localparam int N_DEFAULT = 7;
  localparam int MAX_N     = 32;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_N-1:0] onehot(input int unsigned idx);
    return MAX_N'(1) << idx;
  endfunction

endpackage

// File: rtl/loop_arbiter_pick.sv
// Combinational rotating-priority picker: first set req bit after i_last, wrapping.
// Zero latency, no state; o_vld low when no request is present.
module loop_arbiter_pick
  import loop_arbiter_pkg::*;
#(
  parameter  int N  = N_DEFAULT,
  localparam int PW = ptr_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_last,
  output logic [PW-1:0] o_idx,
  output logic          o_vld
);

  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_mask;
  logic [2*N-1:0] w_masked;

  assign w_dbl    = {i_req, i_req};
  assign w_masked = w_dbl & w_mask;
  assign o_vld    = |i_req;

  // Masking everything at or below i_last makes the lowest surviving bit of the
  // doubled vector the next requester in ring order.
  always_comb begin
    w_mask = '0;
    o_idx  = '0;
    for (int j = 0; j < 2*N; j++) begin
      w_mask[j] = (j > int'(i_last));
    end
    for (int j = 2*N-1; j >= 0; j--) begin
      if (w_masked[j]) begin
        o_idx = (j >= N) ? PW'(j - N) : PW'(j);
      end
    end
  end

endmodule

// File: rtl/loop_arbiter.sv
// Registered round-robin arbiter, 1-cycle req->grant; i_arb_en holds grant and pointer.
// Optional assertion checker compiled in with LOOP_ARB_CHECK_EN.
module loop_arbiter
  import loop_arbiter_pkg::*;
#(
  parameter  int N  = N_DEFAULT,
  localparam int PW = ptr_w(N)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_arb_en,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_grant
);

  logic [N-1:0]  r_grant;
  logic [PW-1:0] r_last;
  logic [PW-1:0] w_idx;
  logic          w_vld;

  loop_arbiter_pick #(.N(N)) u_pick (
    .i_req  (i_req),
    .i_last (r_last),
    .o_idx  (w_idx),
    .o_vld  (w_vld)
  );

  // Pointer resets to N-1 so requester 0 is searched first.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_grant <= '0;
      r_last  <= PW'(N - 1);
    end else if (!i_arb_en) begin
      if (w_vld) begin
        r_grant <= N'(onehot(32'(w_idx)));
        r_last  <= w_idx;
      end else begin
        r_grant <= '0;
      end
    end
  end

  assign o_grant = r_grant;

`ifdef LOOP_ARB_CHECK_EN
  a_onehot0 : assert property (@(posedge i_clk) $onehot0(o_grant))
    else $error("loop_arbiter: grant not one-hot/zero: %b", o_grant);

  a_subset : assert property (@(posedge i_clk)
      (!$past(i_rst) && !$past(i_arb_en)) |-> ((o_grant & ~$past(i_req)) == '0))
    else $error("loop_arbiter: grant %b outside previous req", o_grant);

  a_hold : assert property (@(posedge i_clk)
      (!$past(i_rst) && $past(i_arb_en)) |-> $stable(o_grant))
    else $error("loop_arbiter: grant changed during hold");

  a_reset : assert property (@(posedge i_clk) $past(i_rst) |-> (o_grant == '0))
    else $error("loop_arbiter: grant nonzero after reset");
`else
  // Checker compiled out; datapath identical.
`endif

endmodule

// File: tb/tb_loop_arbiter.sv
// Scoreboard bench: ring-search reference model pushes expected grants, monitor compares.
module tb_loop_arbiter;

  localparam int N = 7;

  logic         clk    = 1'b0;
  logic         rst    = 1'b1;
  logic         arb_en = 1'b0;
  logic [N-1:0] req    = '0;
  logic [N-1:0] grant;

  always #5 clk = ~clk;

  loop_arbiter #(.N(N)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_arb_en (arb_en),
    .i_req    (req),
    .o_grant  (grant)
  );

  logic [N-1:0] exp_q[$];
  string        tag_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;

  // Reference model: index of last winner and current winner (-1 = none).
  int m_last = N - 1;
  int m_win  = -1;

  task automatic step(input logic r, input logic e, input logic [N-1:0] q, input string tag);
    logic [N-1:0] ev;
    @(negedge clk);
    rst    = r;
    arb_en = e;
    req    = q;
    if (r) begin
      m_win  = -1;
      m_last = N - 1;
    end else if (!e) begin
      m_win = -1;
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (q[idx] && m_win < 0) m_win = idx;
      end
      if (m_win >= 0) m_last = m_win;
    end
    ev = '0;
    if (m_win >= 0) ev[m_win] = 1'b1;
    exp_q.push_back(ev);
    tag_q.push_back(tag);
  endtask

  initial begin : monitor
    logic [N-1:0] e;
    string        t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_tests++;
        if (grant !== e) begin
          n_fail++;
          $display("FAIL %s: grant=%b expected=%b", t, grant, e);
        end
      end
    end
  end

  initial begin : stim
    logic [N-1:0] q;
    logic         r;
    logic         e;

    step(1'b1, 1'b0, 7'b0000000, "reset0");
    step(1'b1, 1'b0, 7'b0000000, "reset1");
    step(1'b0, 1'b0, 7'b1001010, "first_pick");
    step(1'b0, 1'b0, 7'b1001001, "rotate_past_last");
    step(1'b0, 1'b0, 7'b1001101, "skip_4_5");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 7'b1001101, "wrap_rotation");

    step(1'b1, 1'b0, 7'b0000000, "reset_all");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 7'h7F, "all_requesting");

    step(1'b0, 1'b0, 7'b0001000, "single_bit3");
    step(1'b0, 1'b0, 7'b0001000, "single_repeat");
    step(1'b0, 1'b0, 7'b0000000, "idle");
    step(1'b0, 1'b0, 7'b0010001, "after_idle_bit4");
    step(1'b0, 1'b1, 7'b0000001, "hold_bit4");
    step(1'b0, 1'b1, 7'b0000000, "hold_req_dropped");
    step(1'b0, 1'b0, 7'b0000001, "release_bit0");

    step(1'b0, 1'b0, 7'b0000100, "get_bit2");
    step(1'b0, 1'b1, 7'b1111111, "hold_bit2");
    step(1'b1, 1'b1, 7'b1111111, "reset_mid_hold");
    step(1'b0, 1'b0, 7'h7F, "after_reset_bit0");
    step(1'b0, 1'b0, 7'b0000000, "idle_zero");
    step(1'b0, 1'b1, 7'b0100000, "hold_zero");

    for (int i = 0; i < 400; i++) begin
      q = N'($urandom);
      if ($urandom_range(0, 1) == 1) q = q & N'($urandom);
      r = ($urandom_range(0, 39) == 0);
      e = ($urandom_range(0, 3) == 0);
      step(r, e, q, "random");
    end

    @(posedge clk);
    #3;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
